uart_tx_buffer: RTL

//  Byte queue between the CPU store path and the UART transmitter. Accepts bytes at CPU rate

---
 rtl/uart_tx_buffer_pkg.sv | 21 ++
 rtl/uart_sync_fifo.sv | 85 ++++++++
 rtl/uart_tx_buffer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/uart_tx_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_buffer_pkg
//  Purpose  : Shared types for the UART transmit buffer. Holds the data width
//             and the launch FSM state encoding used by uart_tx_buffer.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package uart_tx_buffer_pkg;

    localparam int DATA_W = 8;

    // Launch FSM. Encoding 2'd3 is unused and recovers to S_IDLE.
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LAUNCH    = 2'd1,
        S_WAIT_DONE = 2'd2
    } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_sync_fifo
//  Purpose  : Synchronous byte FIFO with registered full/empty/level flags.
//  Ports    : CLK, RST        clock, asynchronous active-high reset
//             wr_en, wr_data  push (caller guarantees room or a same-edge pop)
//             rd_en           pop (caller guarantees not empty)
//             rd_data         head entry, combinational from storage
//             full, empty     registered occupancy flags
//             level           registered entry count, 0..DEPTH
//  Revision : 1.0  initial release
// ============================================================================
module uart_sync_fifo
    import uart_tx_buffer_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level
);

    localparam logic [ADDR_W-1:0] C_PTR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   C_CNT_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   C_FULL    = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_full;
    logic              r_empty;
    logic [ADDR_W:0]   w_count_next;

    always_comb begin
        w_count_next = r_count;
        case ({wr_en, rd_en})
            2'b10:   w_count_next = r_count + C_CNT_ONE;
            2'b01:   w_count_next = r_count - C_CNT_ONE;
            default: w_count_next = r_count;
        endcase
    end

    // Storage has no reset; contents are meaningless once pointers clear.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (wr_en) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (rd_en) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == C_FULL);
            r_empty <= (w_count_next == '0);
        end
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign full    = r_full;
    assign empty   = r_empty;
    assign level   = r_count;

endmodule
`default_nettype wire

// File: rtl/uart_tx_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_buffer
//  Purpose  : Byte queue between the CPU store path and a UART transmitter.
//             Bytes are accepted at CPU rate; one byte per frame is launched
//             with a single-cycle Tx_DV_out pulse, then the block waits for
//             the transmitter's Tx_Done_in pulse before launching another.
//  Ports    : CLK, RST         clock, asynchronous active-high reset
//             Wr_En_in/Wr_Data_in   byte write strobe and data
//             Clr_Err_in       clears the sticky overflow flag
//             Full_out, Empty_out, Level_out   FIFO status
//             Overflow_out     sticky: a write was dropped while full
//             Busy_out         launch FSM not idle
//             Tx_DV_out, Tx_Byte_out   launch strobe and byte to transmitter
//             Tx_Active_in, Tx_Done_in status from transmitter
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_buffer
    import uart_tx_buffer_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Wr_En_in,
    input  logic [DATA_W-1:0] Wr_Data_in,
    input  logic              Clr_Err_in,
    output logic              Full_out,
    output logic              Empty_out,
    output logic [ADDR_W:0]   Level_out,
    output logic              Overflow_out,
    output logic              Busy_out,
    output logic              Tx_DV_out,
    output logic [DATA_W-1:0] Tx_Byte_out,
    input  logic              Tx_Active_in,
    input  logic              Tx_Done_in
);

    tx_state_e         r_state;
    tx_state_e         w_state_next;
    logic              w_launch;
    logic              w_fifo_wr;
    logic              w_ovf_set;
    logic              w_full;
    logic              w_empty;
    logic [DATA_W-1:0] w_head;

    logic              r_overflow;
    logic              r_busy;
    logic              r_dv;
    logic [DATA_W-1:0] r_byte;

    // A write at full is still taken when the head is popped on the same
    // edge, since a slot frees up as the new byte lands.
    assign w_fifo_wr = Wr_En_in && (!w_full || w_launch);
    assign w_ovf_set = Wr_En_in && w_full && !w_launch;

    uart_sync_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .wr_en   (w_fifo_wr),
        .wr_data (Wr_Data_in),
        .rd_en   (w_launch),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .level   (Level_out)
    );

    always_comb begin
        w_state_next = r_state;
        w_launch     = 1'b0;
        case (r_state)
            S_IDLE: begin
                // The Tx_Active_in guard also covers a frame still running
                // in the transmitter after this block was reset.
                if (!w_empty && !Tx_Active_in) begin
                    w_state_next = S_LAUNCH;
                    w_launch     = 1'b1;
                end
            end
            S_LAUNCH: begin
                w_state_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (Tx_Done_in) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_dv       <= 1'b0;
            r_byte     <= '0;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_dv    <= w_launch;
            r_busy  <= (w_state_next != S_IDLE);
            if (w_launch) begin
                r_byte <= w_head;
            end
            // A fresh overflow on the clearing edge keeps the flag set.
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (Clr_Err_in) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign Full_out     = w_full;
    assign Empty_out    = w_empty;
    assign Overflow_out = r_overflow;
    assign Busy_out     = r_busy;
    assign Tx_DV_out    = r_dv;
    assign Tx_Byte_out  = r_byte;

endmodule
`default_nettype wire
